// File: rtl/nmos_piso_shr_if.sv
// Bus bundle for the nmos_piso_shr two-phase PISO shift register.
// The master modport drives phase enables, load controls and data; the slave
// modport is the register side.
interface nmos_piso_shr_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic             C1;
  logic             C2;
  logic             LD;
  logic [WIDTH-1:0] D;
  logic             SI;
  logic             SO;
  logic [WIDTH-1:0] Q;
  logic             BUSY;
  logic [CntW-1:0]  CNT;
  logic             ERR;

  modport master (
    output C1, C2, LD, D, SI,
    input  SO, Q, BUSY, CNT, ERR
  );

  modport slave (
    input  C1, C2, LD, D, SI,
    output SO, Q, BUSY, CNT, ERR
  );
endinterface

// File: rtl/nmos_piso_shr.sv
// Two-phase dynamic parallel-in / serial-out shift register (NMOS sim library).
// A word is loaded into the master stage on a C2 pulse with LD, copied to the
// slave stage on C1, and then shifted toward SO one bit per C2/C1 pair.
// Optional macro NMOS_DYN_DECAY_EN: the slave stage decays to all ones after
// DECAY_CYC main_clk cycles without a C1 pulse.
module nmos_piso_shr #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned DECAY_CYC = 64
) (
  input logic            main_clk,
  input logic            main_rst,
  nmos_piso_shr_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  // StLoaded: fresh word in master; StShifted: master shifted, not yet
  // delivered; StHeld: last shift delivered, waiting for the next C2.
  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StLoaded  = 2'd1;
  localparam logic [1:0] StShifted = 2'd2;
  localparam logic [1:0] StHeld    = 2'd3;

  if (WIDTH < 2 || DECAY_CYC < 1) begin : g_param_check
    $error("nmos_piso_shr: WIDTH must be >= 2 and DECAY_CYC >= 1");
  end

  logic [WIDTH-1:0] master_q, master_d;
  logic [WIDTH-1:0] slave_q, slave_d;
  logic [WIDTH-1:0] slave_eff;
  logic [WIDTH-1:0] shifted;
  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             c1_only;
  logic             c2_only;
  logic             overlap;

  assign c1_only = bus.C1 & ~bus.C2;
  assign c2_only = bus.C2 & ~bus.C1;
  assign overlap = bus.C1 & bus.C2;

`ifdef NMOS_DYN_DECAY_EN
  localparam int unsigned DcW = $clog2(DECAY_CYC + 1);

  logic [DcW-1:0] dcnt_q;
  logic           decayed;

  // Cycles since the last legal C1, saturating at DECAY_CYC.
  always_ff @(posedge main_clk) begin
    if (main_rst) begin
      dcnt_q <= '0;
    end else if (c1_only) begin
      dcnt_q <= '0;
    end else if (dcnt_q != DcW'(DECAY_CYC)) begin
      dcnt_q <= dcnt_q + DcW'(1);
    end
  end

  assign decayed   = (dcnt_q == DcW'(DECAY_CYC));
  assign slave_eff = decayed ? '1 : slave_q;
`else
  assign slave_eff = slave_q;
`endif

  // Slave contents moved one place toward SO with SI filling the vacated end.
  always_comb begin
    shifted = '0;
    if (MSB_FIRST) begin
      shifted = {slave_eff[WIDTH-2:0], bus.SI};
    end else begin
      shifted = {bus.SI, slave_eff[WIDTH-1:1]};
    end
  end

  // Phase-driven next state: C2 loads or shifts master, C1 copies to slave.
  always_comb begin
    master_d = master_q;
    slave_d  = slave_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (overlap) begin
      err_d = 1'b1;
    end else if (c2_only) begin
      if (bus.LD) begin
        master_d = bus.D;
        cnt_d    = '0;
        state_d  = StLoaded;
      end else if (state_q != StIdle) begin
        master_d = shifted;
        state_d  = StShifted;
      end
    end else if (c1_only) begin
      slave_d = master_q;
      if (state_q == StShifted) begin
        if (cnt_q != CntW'(WIDTH)) begin
          cnt_d = cnt_q + CntW'(1);
        end
        state_d = (cnt_q == CntW'(WIDTH - 1)) ? StIdle : StHeld;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge main_clk) begin
    if (main_rst) begin
      master_q <= '0;
      slave_q  <= '0;
      state_q  <= StIdle;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      master_q <= master_d;
      slave_q  <= slave_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign bus.Q    = slave_eff;
  assign bus.SO   = MSB_FIRST ? slave_eff[WIDTH-1] : slave_eff[0];
  assign bus.BUSY = (state_q != StIdle);
  assign bus.CNT  = cnt_q;
  assign bus.ERR  = err_q;
endmodule

// File: tb/tb_nmos_piso_shr.sv
// Self-checking bench for nmos_piso_shr: one MSB-first and one LSB-first
// instance. Stimulus pushes hand-computed expectations into per-instance
// queues; a monitor per instance pops and compares after every C1, reset or
// probe cycle.
module tb_nmos_piso_shr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nmos_piso_shr_if #(.WIDTH(8)) bus_m ();
  nmos_piso_shr_if #(.WIDTH(8)) bus_l ();

  nmos_piso_shr #(.WIDTH(8), .MSB_FIRST(1'b1), .DECAY_CYC(16)) dut_m (
    .main_clk (clk),
    .main_rst (rst),
    .bus      (bus_m)
  );

  nmos_piso_shr #(.WIDTH(8), .MSB_FIRST(1'b0), .DECAY_CYC(16)) dut_l (
    .main_clk (clk),
    .main_rst (rst),
    .bus      (bus_l)
  );

  typedef struct packed {
    logic [7:0] q;
    logic       so;
    logic       busy;
    logic [3:0] cnt;
    logic       err;
  } exp_t;

  exp_t  q_m[$];
  exp_t  q_l[$];
  int    n_chk = 0;
  int    n_fail = 0;
  logic  probe_m = 1'b0;
  string phase = "reset";

  // Hand-computed slave contents and SO after each C1 of a word.
  logic [7:0] msb_q [9] = '{8'hA5, 8'h4A, 8'h94, 8'h28, 8'h50, 8'hA0, 8'h40, 8'h80, 8'h00};
  logic       msb_so[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] lsb_q [9] = '{8'h01, 8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
  logic       lsb_so[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] rl_q  [9] = '{8'h0F, 8'h1E, 8'h3C, 8'h78, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
  logic       rl_so [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  task automatic check(input bit sel);
    exp_t got;
    exp_t want;
    if (sel) got = {bus_l.Q, bus_l.SO, bus_l.BUSY, bus_l.CNT, bus_l.ERR};
    else     got = {bus_m.Q, bus_m.SO, bus_m.BUSY, bus_m.CNT, bus_m.ERR};
    n_chk++;
    if ((sel ? q_l.size() : q_m.size()) == 0) begin
      n_fail++;
      $display("FAIL %s/%s: unexpected output q=%h so=%b busy=%b cnt=%0d err=%b, none required",
               phase, sel ? "lsb" : "msb", got.q, got.so, got.busy, got.cnt, got.err);
    end else begin
      want = sel ? q_l.pop_front() : q_m.pop_front();
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s/%s: got q=%h so=%b busy=%b cnt=%0d err=%b, want q=%h so=%b busy=%b cnt=%0d err=%b",
                 phase, sel ? "lsb" : "msb", got.q, got.so, got.busy, got.cnt, got.err,
                 want.q, want.so, want.busy, want.cnt, want.err);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (bus_m.C1 || rst || probe_m) begin
      #1;
      check(1'b0);
    end
  end

  initial forever begin
    @(posedge clk);
    if (bus_l.C1 || rst) begin
      #1;
      check(1'b1);
    end
  end

  task automatic want(input bit sel, input logic [7:0] q, input logic so, input logic busy,
                      input logic [3:0] cnt, input logic err);
    exp_t e;
    e = {q, so, busy, cnt, err};
    if (sel) q_l.push_back(e);
    else     q_m.push_back(e);
  endtask

  // Drive one cycle of phase inputs into the selected instance, idle the other.
  task automatic drive(input bit sel, input logic c1, input logic c2, input logic ld,
                       input logic [7:0] d, input logic si);
    bus_m.C1 = sel ? 1'b0 : c1;
    bus_m.C2 = sel ? 1'b0 : c2;
    bus_m.LD = sel ? 1'b0 : ld;
    bus_m.D  = sel ? 8'h00 : d;
    bus_m.SI = sel ? 1'b0 : si;
    bus_l.C1 = sel ? c1 : 1'b0;
    bus_l.C2 = sel ? c2 : 1'b0;
    bus_l.LD = sel ? ld : 1'b0;
    bus_l.D  = sel ? d : 8'h00;
    bus_l.SI = sel ? si : 1'b0;
    @(negedge clk);
  endtask

  // Load d, then deliver the whole word plus one flushing C1.
  task automatic run_word(input bit sel, input logic [7:0] d, input logic si,
                          input logic [7:0] eq[9], input logic eso[9]);
    drive(sel, 1'b0, 1'b1, 1'b1, d, si);
    for (int i = 0; i < 9; i++) begin
      want(sel, eq[i], eso[i], (i < 8), 4'(i), 1'b0);
      drive(sel, 1'b1, 1'b0, 1'b0, 8'h00, si);
      if (i < 8) drive(sel, 1'b0, 1'b1, 1'b0, 8'h00, si);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      want(1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
      want(1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    end
    rst = 1'b0;
  endtask

  initial begin
    do_reset(2);

    phase = "idle";
    for (int i = 0; i < 4; i++) begin
      drive(i[0], 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1);
      want(i[0], 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
      drive(i[0], 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1);
    end

    phase = "msb_word";
    run_word(1'b0, 8'hA5, 1'b0, msb_q, msb_so);

    phase = "lsb_word";
    run_word(1'b1, 8'h01, 1'b1, lsb_q, lsb_so);

    phase = "reload";
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'hF0, 1'b0);
    want(1'b0, 8'hF0, 1'b1, 1'b1, 4'd0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    want(1'b0, 8'hE0, 1'b1, 1'b1, 4'd1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    want(1'b0, 8'hC0, 1'b1, 1'b1, 4'd2, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    want(1'b0, 8'h80, 1'b1, 1'b1, 4'd3, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    run_word(1'b0, 8'h0F, 1'b0, rl_q, rl_so);

    phase = "overlap";
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0);
    want(1'b0, 8'hA5, 1'b1, 1'b1, 4'd0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    want(1'b0, 8'hA5, 1'b1, 1'b1, 4'd0, 1'b0);  // repeated C1 is idempotent
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    want(1'b0, 8'h4A, 1'b0, 1'b1, 4'd1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    want(1'b0, 8'h4A, 1'b0, 1'b1, 4'd1, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    want(1'b0, 8'h94, 1'b1, 1'b1, 4'd2, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    want(1'b0, 8'h28, 1'b0, 1'b1, 4'd3, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    phase = "reset_mid";
    do_reset(1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    want(1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

`ifdef NMOS_DYN_DECAY_EN
    phase = "decay";
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    want(1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      if (k >= 16) want(1'b0, 8'hFF, 1'b1, 1'b1, 4'd0, 1'b0);
      else         want(1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b0);
      probe_m = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    end
    probe_m = 1'b0;
    want(1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
`endif

    phase = "drain";
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    n_chk++;
    if (q_m.size() != 0 || q_l.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d pending expectations, want 0/0", q_m.size(), q_l.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
